// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and small decode helpers used by the top level.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  // Upper op bit selects the divide family.
  function automatic logic op_is_div(input logic [1:0] op_code);
    return op_code[1];
  endfunction

  // Lower op bit clear means the signed variant (MULT / DIV).
  function automatic logic op_is_signed(input logic [1:0] op_code);
    return ~op_code[0];
  endfunction

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore the result sign after the unsigned iterative engine.
module mdu_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  // Negate when requested, otherwise pass through unchanged.
  always_comb begin
    o_val = i_val;
    if (i_neg) begin
      o_val = ~i_val + W'(1);
    end
  end

endmodule

// File: rtl/mdu_seq_unit.sv
// Multicycle multiply/divide unit owning HI/LO. One shared unsigned engine
// runs shift-add multiply or restoring divide, one bit per cycle, on operand
// magnitudes; signs are reapplied in the FIX state.
module mdu_seq_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_e         r_state;
  mdu_state_e         w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;       // {partial product | remainder, multiplier | quotient}
  logic [WIDTH-1:0]   r_opnd;      // multiplicand magnitude or divisor magnitude
  logic               r_is_div;
  logic               r_neg_res;   // negate product / quotient in FIX
  logic               r_neg_rem;   // negate remainder in FIX
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_zero_req;
  logic               w_go;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_signed   = op_is_signed(op);
  assign w_a_neg    = w_signed & a[WIDTH-1];
  assign w_b_neg    = w_signed & b[WIDTH-1];
  assign w_zero_req = start & op_is_div(op) & (b == '0);
  assign w_go       = start & ~w_zero_req;

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // the correct unsigned magnitude.
  mdu_abs_neg #(.W(WIDTH)) u_abs_a (.i_val(a), .i_neg(w_a_neg), .o_val(w_abs_a));
  mdu_abs_neg #(.W(WIDTH)) u_abs_b (.i_val(b), .i_neg(w_b_neg), .o_val(w_abs_b));

  // Result sign restoration for the full product and for quotient/remainder.
  mdu_abs_neg #(.W(2*WIDTH)) u_neg_prod (.i_val(r_acc), .i_neg(r_neg_res), .o_val(w_prod_fix));
  mdu_abs_neg #(.W(WIDTH)) u_neg_quo (.i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_res), .o_val(w_quo_fix));
  mdu_abs_neg #(.W(WIDTH)) u_neg_rem (.i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_rem), .o_val(w_rem_fix));

  // One shift-add multiply step: add multiplicand when the multiplier LSB is
  // set, then shift the whole accumulator right keeping the carry.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  end

  // One restoring divide step: trial-subtract the divisor from the shifted
  // remainder and shift in the quotient bit.
  always_comb begin
    w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
    if (!w_div_trial[WIDTH]) begin
      w_div_next = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_div_next = {r_acc[2*WIDTH-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_go) w_state_next = CALC;
      CALC:    if (r_cnt == '0) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Engine: load magnitudes on launch, iterate in CALC.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc     <= '0;
      r_opnd    <= '0;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_is_div  <= op_is_div(op);
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= op_is_div(op) & w_a_neg;
            r_cnt     <= CNT_W'(WIDTH - 1);
            if (op_is_div(op)) begin
              r_opnd <= w_abs_b;
              r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
            end else begin
              r_opnd <= w_abs_a;
              r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
            end
          end
        end
        CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // HI/LO, MTHI/MTLO writes and the registered status pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_zero_req) begin
            r_div_zero <= 1'b1;
          end else if (!start) begin
            if (hi_wr) r_hi <= wdata;
            if (lo_wr) r_lo <= wdata;
          end
        end
        FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_mdu_seq_unit.sv
// Scoreboard bench for mdu_seq_unit: expected HI/LO pushed at launch, popped
// and compared on each done pulse; latency, busy length, div-by-zero, MTHI/MTLO
// gating, ignored restart and mid-operation reset are checked inline.
module tb_mdu_seq_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             hi_wr = 1'b0;
  logic             lo_wr = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [63:0] sb[$];
  logic [WIDTH-1:0] m_hi = '0;
  logic [WIDTH-1:0] m_lo = '0;

  mdu_seq_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'b00: r = 64'(sx * sy);
      2'b01: r = ux * uy;
      2'b10: begin
        sq = sx / sy;
        sr = sx % sy;
        r = {sr[31:0], sq[31:0]};
      end
      default: begin
        uq = ux / uy;
        ur = ux % uy;
        r = {ur[31:0], uq[31:0]};
      end
    endcase
    return r;
  endfunction

  // Scoreboard consumer: one expected entry per done pulse.
  always @(negedge clk) begin
    if (done) begin
      logic [63:0] e;
      done_cnt++;
      chk("sb_depth", 64'(sb.size()), 64'd1);
      chk("busy_at_done", {63'd0, busy}, 64'd0);
      chk("dz_at_done", {63'd0, div_zero}, 64'd0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e[63:32]});
        chk("lo", {32'd0, lo}, {32'd0, e[31:0]});
        m_hi = e[63:32];
        m_lo = e[31:0];
        $display("TXN done hi=%h lo=%h exp_hi=%h exp_lo=%h", hi, lo, e[63:32], e[31:0]);
      end
    end
  end

  // Launch one operation; optional second start at E+restart_k and reset
  // asserted at E+reset_k (negative disables). Called at posedge+1.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int restart_k, input int reset_k);
    int busy_n;
    int done_k;
    int saved;
    bit aborted;
    busy_n = 0;
    done_k = -1;
    aborted = 0;
    saved = done_cnt;
    sb.push_back(model(o, x, y));
    $display("TXN start op=%0d a=%h b=%h", o, x, y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= WIDTH + 4; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k == reset_k) begin
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        reset = 1'b1;
        void'(sb.pop_back());
        m_hi = '0;
        m_lo = '0;
        aborted = 1;
        break;
      end
      if (busy) busy_n++;
      if (done) begin
        done_k = k;
        break;
      end
      if (k == 2) begin
        hi_wr = 1'b1;
        wdata = 32'hDEADBEEF;
      end
      if (k == 3) begin
        hi_wr = 1'b0;
        chk("hi_calc", {32'd0, hi}, {32'd0, m_hi});
        chk("lo_calc", {32'd0, lo}, {32'd0, m_lo});
      end
      if (k == restart_k - 1) begin
        start = 1'b1; a = ~x; b = y ^ 32'h1; op = o ^ 2'b01;
      end
      if (k == restart_k) start = 1'b0;
      if (k == reset_k - 1) reset = 1'b0;
    end
    start = 1'b0;
    if (aborted) begin
      repeat (WIDTH + 4) @(posedge clk);
      #1;
      chk("no_done_after_rst", 64'(done_cnt), 64'(saved));
    end else begin
      chk("done_latency", 64'(done_k), 64'(WIDTH + 1));
      chk("busy_cycles", 64'(busy_n), 64'(WIDTH + 1));
      repeat (3) @(posedge clk);
      #1;
      chk("single_done", 64'(done_cnt), 64'(saved + 1));
    end
  endtask

  // Preset HI/LO, then a DIV by zero with a concurrent (dropped) MTHI.
  task automatic div_zero_case();
    hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h12345678;
    @(posedge clk); #1;
    hi_wr = 1'b0; lo_wr = 1'b0;
    m_hi = 32'h12345678;
    m_lo = 32'h12345678;
    chk("mt_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("mt_lo", {32'd0, lo}, {32'd0, m_lo});
    $display("TXN start op=2 a=00000005 b=00000000 (divide by zero)");
    start = 1'b1; op = 2'b10; a = 32'h5; b = 32'h0; hi_wr = 1'b1; wdata = 32'h0;
    @(posedge clk); #1;
    start = 1'b0; hi_wr = 1'b0;
    chk("dz_pulse", {63'd0, div_zero}, 64'd1);
    chk("dz_busy", {63'd0, busy}, 64'd0);
    chk("dz_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    chk("dz_clear", {63'd0, div_zero}, 64'd0);
    chk("dz_busy2", {63'd0, busy}, 64'd0);
    chk("dz_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("dz_lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  initial begin
    logic [1:0] ro;
    logic [31:0] ra, rb;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_dz", {63'd0, div_zero}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, -1, -1);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1);
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, -1, -1);
    run_op(2'b11, 32'h00000007, 32'h00000002, -1, -1);
    div_zero_case();
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 5, -1);
    run_op(2'b00, 32'h00001234, 32'hFFFF0001, -1, 10);
    run_op(2'b01, 32'h00000006, 32'h00000007, -1, -1);
    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (rb == 32'd0) rb = 32'd3;
      run_op(ro, ra, rb, -1, -1);
    end
    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_seq_unit.md
Name: mdu_seq_unit

Overview:
- Parametrised multicycle multiply/divide unit for the MIPS datapath; owns the HI and LO architectural registers.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, under a start/busy/done handshake driven by the control unit (multControl/divControl).
- Generalises the fixed 32-bit mult and div blocks:
  - configurable width;
  - a single shared engine for both operations;
  - divide-by-zero detection;
  - direct HI/LO writes (MTHI/MTLO).

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be at least 4.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- hi_wr  in  1  MTHI strobe.
- lo_wr  in  1  MTLO strobe.
- wdata  in  WIDTH  data for hi_wr/lo_wr.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; hi/lo hold the new result.
- div_zero  out  1  one-cycle pulse; DIV/DIVU with b==0 rejected.
- hi  out  WIDTH  HI register (MFHI source).
- lo  out  WIDTH  LO register (MFLO source).

Behaviour:
- Reset:
  - When reset==0 at an edge: state=IDLE; hi, lo, internal accumulators and counter = 0; busy=done=div_zero=0.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE, CALC, FIX.
- IDLE:
  - start==1 and op is DIV/DIVU with b==0: stay IDLE; div_zero=1 for the next cycle; hi/lo unchanged.
  - Otherwise start==1: latch |a|, |b| (signed ops; unsigned ops take raw values), latch result sign flags and op; counter=WIDTH-1; go CALC.
- CALC:
  - MULT/MULTU: radix-2 shift-add over a 2*WIDTH accumulator.
  - DIV/DIVU: restoring division, one quotient bit per cycle.
  - Counter decrements each cycle; when counter==0 go FIX.
- FIX:
  - Apply signs. Signed multiply: negate the 2*WIDTH product if the operand signs differ.
  - Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
  - Write hi = product[2W-1:W] or remainder; write lo = product[W-1:0] or quotient.
  - done=1 for the next cycle; go IDLE.
- Timing:
  - With start sampled at edge E, hi/lo update and done rises at edge E+WIDTH+1.
  - busy=1 from edge E through edge E+WIDTH+1, then 0; busy and done never overlap.
- Overflow: DIV of most-negative by -1 gives lo=most-negative, hi=0 (two's-complement wrap, no flag).
- Handshake conflicts:
  - start while busy is ignored; operands are not re-sampled.
  - hi_wr/lo_wr are honoured only in IDLE with start==0; otherwise they are dropped.
  - hi_wr and lo_wr may assert together.
- Outputs:
  - hi and lo are stable throughout CALC (previous values) and change only in FIX, on reset, or on an MTHI/MTLO write.
  - done and div_zero are registered and never both high.

Decomposition:
- Package mdu_pkg: op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU) and the state enum (IDLE, CALC, FIX).
- One natural sub-module: mdu_abs_neg, a parametrised combinational conditional two's-complement negate. It is instanced for operand magnitudes and for result sign fix.

Test Plan:
- MULT a=FFFFFFFD (-3), b=00000007: hi=FFFFFFFF, lo=FFFFFFEB; done exactly at E+33; busy high 33 cycles.
- MULTU a=b=FFFFFFFF: hi=FFFFFFFE, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=2: lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=7, b=2: lo=3, hi=1.
- DIV b=0 with hi=lo=12345678 preset via hi_wr/lo_wr: div_zero pulse at E+1; busy never rises; hi/lo unchanged.
- DIV 80000000 / FFFFFFFF: lo=80000000, hi=0. Second start pulsed at E+5: ignored, single done.
- MULT started, reset=0 at E+10: hi=lo=0, busy=0, no done. Then MULTU 6*7 gives lo=2A, hi=0.
